// File: rtl/cpu_pkg.sv
// Shared CPU-side definitions used by the elastic pipeline blocks.
package cpu_pkg;

    // Deepest chain of skid stages a pipe_elastic instance may build.
    localparam int PIPE_MAX_STAGES = 8;

    // Occupancy state of a single skid stage.
    typedef enum logic [1:0] {
        PS_EMPTY = 2'd0,
        PS_BUSY  = 2'd1,
        PS_FULL  = 2'd2
    } pipe_stage_e;

endpackage

// File: rtl/pipe_skid_stage.sv
// One registered skid stage: a main register plus a skid register, so the
// ready it presents upstream depends only on its own state.
module pipe_skid_stage
    import cpu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic [1:0]       valid_cnt
);

    pipe_stage_e      state;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;
    logic             s_in;
    logic             s_out;

    assign in_ready  = (state != PS_FULL);
    assign out_valid = (state != PS_EMPTY);
    assign out_data  = main_q;
    assign s_in      = in_valid & in_ready;
    assign s_out     = out_valid & out_ready;

    // Number of held entries, decoded from the stage state.
    always_comb begin
        valid_cnt = 2'd0;
        case (state)
            PS_BUSY: valid_cnt = 2'd1;
            PS_FULL: valid_cnt = 2'd2;
            default: valid_cnt = 2'd0;
        endcase
    end

    // Stage state machine; reset wins over clear, clear wins over handshakes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= PS_EMPTY;
            main_q <= '0;
            skid_q <= '0;
        end else if (clr) begin
            state <= PS_EMPTY;
        end else begin
            case (state)
                PS_EMPTY: begin
                    if (s_in) begin
                        state  <= PS_BUSY;
                        main_q <= in_data;
                    end
                end
                PS_BUSY: begin
                    if (s_in && s_out) begin
                        main_q <= in_data;
                    end else if (s_in) begin
                        state  <= PS_FULL;
                        skid_q <= in_data;
                    end else if (s_out) begin
                        state <= PS_EMPTY;
                    end
                end
                PS_FULL: begin
                    if (s_out) begin
                        state  <= PS_BUSY;
                        main_q <= skid_q;
                    end
                end
                default: state <= PS_EMPTY;
            endcase
        end
    end

endmodule

// File: rtl/pipe_elastic.sv
// Elastic pipeline: a chain of skid stages with flush, global enable and an
// occupancy count of every entry held in the chain.
module pipe_elastic
    import cpu_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int NUM_STAGES = 1,
    parameter int CNT_W      = $clog2(2*NUM_STAGES+1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic [CNT_W-1:0] occupancy
);

    if (NUM_STAGES < 1 || NUM_STAGES > PIPE_MAX_STAGES) begin : g_bad_depth
        $error("pipe_elastic: NUM_STAGES out of range");
    end

    logic             clr;
    logic             valid_chain [NUM_STAGES+1];
    logic [WIDTH-1:0] data_chain  [NUM_STAGES+1];
    logic             ready_chain [NUM_STAGES+1];
    logic [1:0]       cnt_chain   [NUM_STAGES];
    logic [CNT_W-1:0] occ_sum;

    // A disabled pipe behaves exactly like one being flushed every cycle.
    assign clr = flush | ~en;

    assign valid_chain[0]          = in_valid;
    assign data_chain[0]           = in_data;
    assign ready_chain[NUM_STAGES] = out_ready & ~clr;

    assign in_ready  = ready_chain[0] & ~clr;
    assign out_valid = valid_chain[NUM_STAGES];
    assign out_data  = data_chain[NUM_STAGES];
    assign occupancy = occ_sum;

    for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
        pipe_skid_stage #(
            .WIDTH(WIDTH)
        ) u_stage (
            .clk      (clk),
            .rst      (rst),
            .clr      (clr),
            .in_valid (valid_chain[k]),
            .in_data  (data_chain[k]),
            .in_ready (ready_chain[k]),
            .out_valid(valid_chain[k+1]),
            .out_data (data_chain[k+1]),
            .out_ready(ready_chain[k+1]),
            .valid_cnt(cnt_chain[k])
        );
    end

    // Total entries held: sum of the per-stage counts.
    always_comb begin
        occ_sum = '0;
        for (int k = 0; k < NUM_STAGES; k++) begin
            occ_sum = occ_sum + CNT_W'(cnt_chain[k]);
        end
    end

endmodule

// File: tb/tb_pipe_elastic.sv
// Bench for pipe_elastic: four depths (1..4) share one stimulus stream and
// are each compared every cycle against a per-stage two-entry queue model.
module tb_pipe_elastic;

    localparam int NINST = 4;
    localparam int W     = 8;

    logic clk = 1'b0;
    logic rst;
    logic en;
    logic flush;
    logic in_valid;
    logic [W-1:0] in_data;
    logic out_ready;

    logic [NINST-1:0]        rdy_all;
    logic [NINST-1:0]        ov_all;
    logic [NINST-1:0][W-1:0] od_all;
    logic [NINST-1:0][3:0]   occ_all;

    int checks   = 0;
    int failures = 0;

    int         mdl_cnt [NINST][8];
    logic [W-1:0] mdl_q [NINST][8][2];
    logic [W-1:0] sb_mem [NINST][16];
    int         sb_head [NINST];
    int         sb_tail [NINST];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NINST; g++) begin : g_dut
        localparam int N  = g + 1;
        localparam int CW = $clog2(2*N+1);
        logic [CW-1:0] occ;
        pipe_elastic #(
            .WIDTH     (W),
            .NUM_STAGES(N)
        ) dut (
            .clk      (clk),
            .rst      (rst),
            .en       (en),
            .flush    (flush),
            .in_valid (in_valid),
            .in_data  (in_data),
            .in_ready (rdy_all[g]),
            .out_valid(ov_all[g]),
            .out_data (od_all[g]),
            .out_ready(out_ready),
            .occupancy(occ)
        );
        assign occ_all[g] = 4'(occ);
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic modelClear(input int i);
        for (int k = 0; k < 8; k++) mdl_cnt[i][k] = 0;
        sb_head[i] = 0;
        sb_tail[i] = 0;
    endtask

    // Compare every instance against the model state held before this edge.
    task automatic compareAll();
        for (int i = 0; i < NINST; i++) begin
            int n;
            int occ;
            logic exp_rdy;
            n = i + 1;
            occ = 0;
            for (int k = 0; k < n; k++) occ += mdl_cnt[i][k];
            exp_rdy = en && !flush && (mdl_cnt[i][0] < 2);
            checkOutput($sformatf("in_ready[n%0d]", n), rdy_all[i], exp_rdy);
            checkOutput($sformatf("out_valid[n%0d]", n), ov_all[i], mdl_cnt[i][n-1] > 0);
            checkOutput($sformatf("occupancy[n%0d]", n), occ_all[i], occ);
            if (mdl_cnt[i][n-1] > 0) begin
                checkOutput($sformatf("out_data[n%0d]", n), od_all[i], mdl_q[i][n-1][0]);
                if (out_ready && en && !flush && !rst) begin
                    if (sb_head[i] == sb_tail[i])
                        checkOutput($sformatf("sb_empty[n%0d]", n), 1, 0);
                    else
                        checkOutput($sformatf("sb_order[n%0d]", n), od_all[i], sb_mem[i][sb_head[i] % 16]);
                end
            end
        end
    endtask

    // Advance each model by one edge: every stage is a FIFO of capacity two.
    task automatic modelStep();
        for (int i = 0; i < NINST; i++) begin
            int n;
            int c[8];
            logic [W-1:0] h[8];
            logic rdy[8];
            logic vld[8];
            n = i + 1;
            if (rst || flush || !en) begin
                modelClear(i);
                continue;
            end
            for (int k = 0; k < 8; k++) begin
                c[k]   = mdl_cnt[i][k];
                h[k]   = mdl_q[i][k][0];
                rdy[k] = c[k] < 2;
                vld[k] = c[k] > 0;
            end
            for (int k = 0; k < n; k++) begin
                logic in_f;
                logic out_f;
                logic [W-1:0] in_d;
                in_f  = (k == 0) ? (in_valid && rdy[0]) : (vld[k-1] && rdy[k]);
                in_d  = (k == 0) ? in_data : h[k-1];
                out_f = (k == n-1) ? (vld[k] && out_ready) : (vld[k] && rdy[k+1]);
                if (out_f) begin
                    mdl_q[i][k][0] = mdl_q[i][k][1];
                    mdl_cnt[i][k]--;
                end
                if (in_f) begin
                    mdl_q[i][k][mdl_cnt[i][k]] = in_d;
                    mdl_cnt[i][k]++;
                end
                if (k == 0 && in_f) begin
                    sb_mem[i][sb_tail[i] % 16] = in_data;
                    sb_tail[i]++;
                end
                if (k == n-1 && out_f) sb_head[i]++;
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        compareAll();
        modelStep();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic r, input logic e, input logic f,
                                 input logic v, input logic [W-1:0] d, input logic ordy);
        rst       = r;
        en        = e;
        flush     = f;
        in_valid  = v;
        in_data   = d;
        out_ready = ordy;
        tick();
    endtask

    initial begin
        int vld_pct;
        int rdy_pct;
        rst = 1'b1; en = 1'b1; flush = 1'b0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        for (int i = 0; i < NINST; i++) modelClear(i);

        // Reset and idle
        repeat (2) @(posedge clk);
        #1;
        for (int g = 0; g < NINST; g++) begin
            checkOutput("rst_out_valid", ov_all[g], 0);
            checkOutput("rst_occupancy", occ_all[g], 0);
            checkOutput("rst_in_ready", rdy_all[g], 1);
            checkOutput("rst_out_data", od_all[g], 0);
        end
        applyStimulus(0, 1, 0, 0, 8'h00, 1);

        // Streaming through the three-stage instance
        for (int c = 0; c < 11; c++) begin
            int m;
            applyStimulus(0, 1, 0, c < 8, 8'(8'h11 + c), 1);
            m = c + 1;
            if (c < 8) checkOutput("stream_in_ready", rdy_all[2], 1);
            if (m >= 3 && m <= 10) begin
                checkOutput("stream_valid", ov_all[2], 1);
                checkOutput("stream_data", od_all[2], 8'(8'h11 + m - 3));
            end else begin
                checkOutput("stream_idle", ov_all[2], 0);
            end
        end

        // Back-pressure on the two-stage instance
        applyStimulus(0, 1, 1, 0, 8'h00, 1);
        for (int j = 0; j < 6; j++) applyStimulus(0, 1, 0, 1, 8'(8'hA0 + j), 0);
        checkOutput("bp_occupancy", occ_all[1], 4);
        checkOutput("bp_in_ready", rdy_all[1], 0);
        checkOutput("bp_head", od_all[1], 8'hA0);
        checkOutput("bp_occupancy_n1", occ_all[0], 2);
        for (int j = 1; j <= 4; j++) begin
            applyStimulus(0, 1, 0, 0, 8'h00, 1);
            if (j <= 3) begin
                checkOutput("drain_valid", ov_all[1], 1);
                checkOutput("drain_data", od_all[1], 8'(8'hA0 + j));
            end else begin
                checkOutput("drain_done", ov_all[1], 0);
            end
        end
        checkOutput("drain_in_ready", rdy_all[1], 1);

        // Flush with full pipes and a simultaneous offer and accept
        for (int j = 0; j < 5; j++) applyStimulus(0, 1, 0, 1, 8'(8'hB0 + j), 0);
        applyStimulus(0, 1, 1, 1, 8'hC0, 1);
        for (int g = 0; g < NINST; g++) begin
            checkOutput("flush_occupancy", occ_all[g], 0);
            checkOutput("flush_out_valid", ov_all[g], 0);
        end
        applyStimulus(0, 1, 0, 0, 8'h00, 1);
        for (int g = 0; g < NINST; g++) checkOutput("flush_no_capture", occ_all[g], 0);

        // Enable held low while input is offered
        for (int j = 0; j < 3; j++) begin
            applyStimulus(0, 0, 0, 1, 8'(8'hD0 + j), 1);
            for (int g = 0; g < NINST; g++) begin
                checkOutput("en_low_in_ready", rdy_all[g], 0);
                checkOutput("en_low_occupancy", occ_all[g], 0);
            end
        end
        applyStimulus(0, 1, 0, 1, 8'hE0, 1);
        for (int m = 1; m <= 5; m++) begin
            for (int g = 0; g < NINST; g++) begin
                checkOutput("en_latency_valid", ov_all[g], m == g + 1);
                if (m == g + 1) checkOutput("en_latency_data", od_all[g], 8'hE0);
            end
            applyStimulus(0, 1, 0, 0, 8'h00, 1);
        end

        // Randomized traffic with occasional flush, disable and reset
        vld_pct = 50;
        rdy_pct = 50;
        for (int c = 0; c < 10000; c++) begin
            if (c % 500 == 0) begin
                vld_pct = $urandom_range(10, 95);
                rdy_pct = $urandom_range(10, 95);
            end
            applyStimulus($urandom_range(0, 511) == 0,
                          $urandom_range(0, 63) != 0,
                          $urandom_range(0, 127) == 0,
                          $urandom_range(0, 99) < vld_pct,
                          8'($urandom),
                          $urandom_range(0, 99) < rdy_pct);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
